// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register-file write port, with a
// sequenced bulk-clear sweep issued through the same port.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_rw,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_rw,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] Rw,
    output logic              WrEn,
    output logic [DATA_W-1:0] busW,
    output logic              grant_id
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   rw_q, rw_d;
    logic [DATA_W-1:0]   busw_q, busw_d;
    logic                grant_q, grant_d;
    logic                pick0;

    // Arbitration, clear sequencing and next-state for the write port.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        wren_d       = 1'b0;
        rw_d         = rw_q;
        busw_d       = busw_q;
        grant_d      = grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        pick0        = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                end else begin
                    if (req0_valid && req1_valid) begin
                        pick0 = (FIXED_PRI != 0) || last_grant_q;
                        req0_ready = pick0;
                        req1_ready = !pick0;
                    end else begin
                        req0_ready = req0_valid;
                        req1_ready = req1_valid;
                    end

                    if (req0_ready) begin
                        wren_d       = 1'b1;
                        rw_d         = req0_rw;
                        busw_d       = req0_data;
                        grant_d      = 1'b0;
                        last_grant_d = 1'b0;
                    end else if (req1_ready) begin
                        wren_d       = 1'b1;
                        rw_d         = req1_rw;
                        busw_d       = req1_data;
                        grant_d      = 1'b1;
                        last_grant_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wren_d  = 1'b1;
                rw_d    = cnt_q;
                busw_d  = '0;
                grant_d = 1'b0;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            wren_q       <= 1'b0;
            rw_q         <= '0;
            busw_q       <= '0;
            grant_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            wren_q       <= wren_d;
            rw_q         <= rw_d;
            busw_q       <= busw_d;
            grant_q      <= grant_d;
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign WrEn     = wren_q;
    assign Rw       = rw_q;
    assign busW     = busw_q;
    assign grant_id = grant_q;

endmodule
